float_signed_round_pipe: RTL and testbench
==========================================

# float_signed_round_pipe

Pipelined round-to-nearest-even stage for signed floats. Consumes the frac/trailing-bits/sticky triple that the narrowing stage emits and produces a correctly rounded signed float of the same FRAC and EXP widths, including exponent carry and overflow-to-infinity. Sits directly downstream of the signed-float narrow stage; a two-deep valid/ready pipeline lets it drop into streaming datapaths.

## Interface
- FRAC, 8, fraction width of input and output (excluding hidden bit)
- EXP, 8, biased unsigned exponent width
- TRAILING_BITS, 2, guard bits below frac; MSB is round bit, rest are sticky; must be ≥1
- clock  in  1  rising-edge clock
- resetn  in  1  asynchronous, active-low reset
- inValid  in  1  input beat valid
- inReady  out  1  stage can accept a beat
- inSign / inIsInf / inIsZero  in  1 each  input flags
- inExp  in  EXP  biased exponent
- inFrac  in  FRAC  fraction
- inTrailingBits  in  TRAILING_BITS  guard bits
- inStickyBit  in  1  OR of all bits below the guard bits
- outValid  in/out: out  1  output beat valid
- outReady  in  1  consumer accepts
- outSign / outIsInf / outIsZero  out  1 each  result flags
- outExp  out  EXP  result exponent
- outFrac  out  FRAC  result fraction
- outInexact  out  1  any discarded bit nonzero (finite, nonzero inputs only)

## Operation
- R = inTrailingBits[TRAILING_BITS-1]; S = OR(inTrailingBits[TRAILING_BITS-2:0]) | inStickyBit; L = inFrac[0].
- Round up iff R & (S | L). Inexact = R | S.
- Stage 1 (decide): register flags, exp, frac+roundUp as FRAC+1 bits (carry), inexact.
- Stage 2 (adjust): carry set → frac = 0, exp = exp+1; if exp was 2^EXP-2 or all-ones before increment (result ≥ all-ones), set isInf=1, exp=0, frac=0. Else pass through.
- inIsZero or inIsInf: no rounding, inexact=0, exp/frac forced 0, sign passed.
- Both inIsZero and inIsInf set: isInf wins, isZero cleared.
- Sign never altered.

## Timing
- Latency exactly 2 cycles from accepted input beat to outValid with no stall.
- Throughput 1 beat/cycle while outReady=1.
- Beat accepted when inValid & inReady; emitted when outValid & outReady.
- Stall: inReady = !s1Valid | !s2Valid | outReady (pipeline advances as bubbles allow); stage 1 moves into stage 2 when stage 2 empty or draining that cycle.
- outValid must not drop and output data must stay stable while outReady=0.
- inReady is combinational from outReady and valid flags only, never from inValid.
- Reset: all valid flags 0, all output data 0, inReady=1 after reset release; reset mid-stream discards in-flight beats.
- Simultaneous accept and emit in same cycle with full pipeline is legal and loses no beat.

## Configuration
- FLOAT_ROUND_STATS_EN defined: adds outputs statInexactCount[15:0] and statOverflowCount[15:0]; each increments on emitted beats with inexact / overflow-to-inf respectively; saturates at 16'hFFFF; input statClear (1) synchronously zeros both; both reset to 0.
- Undefined: ports and counters absent; no other behaviour change.

## Structure
- Package float_round_pkg: RoundDecision typedef struct (roundUp, inexact), constant helpers for exponent all-ones and pre-overflow values.
- Sub-module float_round_decide: combinational R/S/L extraction and RNE decision, parameterised on TRAILING_BITS; instantiated in stage 1.

## Test plan (FRAC=8, EXP=8, TRAILING_BITS=2)
- frac 8'h55, trail 2'b10, sticky 0 (tie, L=1) → frac 8'h56, inexact 1, 2 cycles later.
- frac 8'h54, trail 2'b10, sticky 0 (tie, L=0) → frac 8'h54, inexact 1; trail 2'b00 sticky 0 → inexact 0.
- frac 8'hFF, exp 8'h10, trail 2'b11 → frac 8'h00, exp 8'h11.
- frac 8'hFF, exp 8'hFE, trail 2'b11 → isInf 1, exp 0, frac 0 (stats: overflow count 1).
- 4 back-to-back beats with outReady held 0 for 3 cycles mid-stream → inReady drops once both stages full, all 4 beats emitted in order, data stable during stall.
- resetn asserted with 2 beats in flight → outValid 0 immediately, no beats emitted after release; inIsZero=1 with trail 2'b11 → outIsZero 1, frac 0, inexact 0.

Source files
------------

// File: rtl/float_round_pkg.sv
// Shared types and exponent constants for the signed-float rounding pipeline.
package float_round_pkg;

  typedef struct packed {
    logic roundUp;
    logic inexact;
  } RoundDecision;

  function automatic int unsigned expAllOnes(input int unsigned expWidth);
    return (32'd1 << expWidth) - 32'd1;
  endfunction

  // A carry out of this exponent or above lands on all-ones, i.e. infinity.
  function automatic int unsigned expPreOverflow(input int unsigned expWidth);
    return expAllOnes(expWidth) - 32'd1;
  endfunction

endpackage

// File: rtl/float_signed_round_pipe_if.sv
// Valid/ready stream bundle between the rounding pipe and its producer/consumer.
interface float_signed_round_pipe_if #(
  parameter int FRAC          = 8,
  parameter int EXP           = 8,
  parameter int TRAILING_BITS = 2
);
  logic                     inValid;
  logic                     inReady;
  logic                     inSign;
  logic                     inIsInf;
  logic                     inIsZero;
  logic [EXP-1:0]           inExp;
  logic [FRAC-1:0]          inFrac;
  logic [TRAILING_BITS-1:0] inTrailingBits;
  logic                     inStickyBit;

  logic                     outValid;
  logic                     outReady;
  logic                     outSign;
  logic                     outIsInf;
  logic                     outIsZero;
  logic [EXP-1:0]           outExp;
  logic [FRAC-1:0]          outFrac;
  logic                     outInexact;

  modport master (
    output inValid, inSign, inIsInf, inIsZero, inExp, inFrac, inTrailingBits, inStickyBit,
    output outReady,
    input  inReady,
    input  outValid, outSign, outIsInf, outIsZero, outExp, outFrac, outInexact
  );

  modport slave (
    input  inValid, inSign, inIsInf, inIsZero, inExp, inFrac, inTrailingBits, inStickyBit,
    input  outReady,
    output inReady,
    output outValid, outSign, outIsInf, outIsZero, outExp, outFrac, outInexact
  );
endinterface

// File: rtl/float_round_decide.sv
// Round-to-nearest-even decision from fraction LSB, guard bits and sticky bit.
module float_round_decide
  import float_round_pkg::*;
#(
  parameter int TRAILING_BITS = 2
) (
  input  logic                     lsb,
  input  logic [TRAILING_BITS-1:0] trailingBits,
  input  logic                     stickyBit,
  output RoundDecision             decision
);

  logic roundBit;
  logic stickyAll;

  assign roundBit = trailingBits[TRAILING_BITS-1];

  generate
    if (TRAILING_BITS > 1) begin : gWide
      assign stickyAll = (|trailingBits[TRAILING_BITS-2:0]) | stickyBit;
    end else begin : gNarrow
      assign stickyAll = stickyBit;
    end
  endgenerate

  assign decision.roundUp = roundBit & (stickyAll | lsb);
  assign decision.inexact = roundBit | stickyAll;

endmodule

// File: rtl/float_signed_round_pipe.sv
// Two-stage RNE rounding pipe (decide, then exponent adjust) with valid/ready flow control.
// Optional FLOAT_ROUND_STATS_EN adds saturating inexact/overflow counters on emitted beats.
module float_signed_round_pipe
  import float_round_pkg::*;
#(
  parameter int FRAC          = 8,
  parameter int EXP           = 8,
  parameter int TRAILING_BITS = 2
) (
  input  logic                      clock,
  input  logic                      resetn,
  float_signed_round_pipe_if.slave  bus
`ifdef FLOAT_ROUND_STATS_EN
  ,
  input  logic                      statClear,
  output logic [15:0]               statInexactCount,
  output logic [15:0]               statOverflowCount
`endif
);

  localparam logic [EXP-1:0] EXP_PRE_OVF = EXP'(expPreOverflow(EXP));

  RoundDecision decision;
  logic         special;
  logic         s1Valid;
  logic         s1Sign;
  logic         s1IsInf;
  logic         s1IsZero;
  logic [EXP-1:0]  s1Exp;
  logic [FRAC:0]   s1Frac;
  logic            s1Inexact;
  logic            carry;
  logic            overflow;
  logic [EXP-1:0]  adjExp;
  logic            s2Advance;

  float_round_decide #(.TRAILING_BITS(TRAILING_BITS)) uDecide (
    .lsb          (bus.inFrac[0]),
    .trailingBits (bus.inTrailingBits),
    .stickyBit    (bus.inStickyBit),
    .decision     (decision)
  );

  assign special   = bus.inIsInf | bus.inIsZero;
  assign bus.inReady = !s1Valid || !bus.outValid || bus.outReady;
  assign s2Advance = !bus.outValid || bus.outReady;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      s1Valid   <= 1'b0;
      s1Sign    <= 1'b0;
      s1IsInf   <= 1'b0;
      s1IsZero  <= 1'b0;
      s1Exp     <= '0;
      s1Frac    <= '0;
      s1Inexact <= 1'b0;
    end else begin
      if (bus.inReady) s1Valid <= bus.inValid;
      if (bus.inReady && bus.inValid) begin
        s1Sign    <= bus.inSign;
        s1IsInf   <= bus.inIsInf;
        s1IsZero  <= bus.inIsZero & ~bus.inIsInf;
        s1Exp     <= special ? '0 : bus.inExp;
        s1Frac    <= special ? '0 : ({1'b0, bus.inFrac} + (FRAC+1)'(decision.roundUp));
        s1Inexact <= ~special & decision.inexact;
      end
    end
  end

  // A carry only happens from an all-ones fraction, so the low bits are already zero.
  assign carry    = s1Frac[FRAC];
  assign overflow = carry && (s1Exp >= EXP_PRE_OVF);
  assign adjExp   = overflow ? '0 : (carry ? s1Exp + EXP'(1) : s1Exp);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      bus.outValid   <= 1'b0;
      bus.outSign    <= 1'b0;
      bus.outIsInf   <= 1'b0;
      bus.outIsZero  <= 1'b0;
      bus.outExp     <= '0;
      bus.outFrac    <= '0;
      bus.outInexact <= 1'b0;
    end else begin
      if (s2Advance) bus.outValid <= s1Valid;
      if (s2Advance && s1Valid) begin
        bus.outSign    <= s1Sign;
        bus.outIsInf   <= s1IsInf | overflow;
        bus.outIsZero  <= s1IsZero;
        bus.outExp     <= adjExp;
        bus.outFrac    <= s1Frac[FRAC-1:0];
        bus.outInexact <= s1Inexact;
      end
    end
  end

`ifdef FLOAT_ROUND_STATS_EN
  logic s2Overflow;
  logic emit;

  assign emit = bus.outValid && bus.outReady;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      s2Overflow        <= 1'b0;
      statInexactCount  <= '0;
      statOverflowCount <= '0;
    end else begin
      if (s2Advance && s1Valid) s2Overflow <= overflow;
      if (statClear) begin
        statInexactCount  <= '0;
        statOverflowCount <= '0;
      end else if (emit) begin
        if (bus.outInexact && statInexactCount != 16'hFFFF)
          statInexactCount <= statInexactCount + 16'd1;
        if (s2Overflow && statOverflowCount != 16'hFFFF)
          statOverflowCount <= statOverflowCount + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_float_signed_round_pipe.sv
// Scoreboard bench for float_signed_round_pipe: random and directed beats vs an arithmetic RNE model.
module tb_float_signed_round_pipe;
  localparam int FRAC  = 8;
  localparam int EXP   = 8;
  localparam int TRAIL = 2;

  typedef struct packed {
    logic            sign;
    logic            isInf;
    logic            isZero;
    logic [EXP-1:0]  exp;
    logic [FRAC-1:0] frac;
    logic            inexact;
  } OutBeat;

  typedef struct packed {
    OutBeat beat;
    logic   ovf;
  } Expect;

  typedef struct packed {
    logic             sign;
    logic             isInf;
    logic             isZero;
    logic [EXP-1:0]   exp;
    logic [FRAC-1:0]  frac;
    logic [TRAIL-1:0] trail;
    logic             sticky;
  } InBeat;

  logic clock = 1'b0;
  logic resetn = 1'b0;
  always #5 clock = ~clock;

  float_signed_round_pipe_if #(.FRAC(FRAC), .EXP(EXP), .TRAILING_BITS(TRAIL)) bus();

`ifdef FLOAT_ROUND_STATS_EN
  logic        statClear;
  logic [15:0] statInexactCount;
  logic [15:0] statOverflowCount;
  int          modelInexact = 0;
  int          modelOverflow = 0;
`endif

  float_signed_round_pipe #(.FRAC(FRAC), .EXP(EXP), .TRAILING_BITS(TRAIL)) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
`ifdef FLOAT_ROUND_STATS_EN
    ,
    .statClear         (statClear),
    .statInexactCount  (statInexactCount),
    .statOverflowCount (statOverflowCount)
`endif
  );

  int    nChecks = 0;
  int    nFails = 0;
  Expect expQ[$];
  bit    randomReady = 1'b0;
  bit    sawInReadyLow = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    nChecks++;
    if (act !== req) begin
      nFails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Rounding from the numeric value of the discarded tail against one half ulp.
  function automatic Expect model(input InBeat b);
    Expect e;
    int tail, half, m, ex;
    bit up;
    e = '0;
    e.beat.sign = b.sign;
    if (b.isInf) begin
      e.beat.isInf = 1'b1;
    end else if (b.isZero) begin
      e.beat.isZero = 1'b1;
    end else begin
      tail = int'(b.trail) * 2 + int'(b.sticky);
      half = 1 << TRAIL;
      up = (tail > half) || (tail == half && (int'(b.frac) % 2) == 1);
      m = int'(b.frac) + int'(up);
      ex = int'(b.exp);
      e.beat.inexact = (tail != 0);
      if (m == (1 << FRAC)) begin
        m = 0;
        ex = ex + 1;
        if (ex >= (1 << EXP) - 1) begin
          e.beat.isInf = 1'b1;
          e.ovf = 1'b1;
          ex = 0;
        end
      end
      e.beat.exp = ex[EXP-1:0];
      e.beat.frac = m[FRAC-1:0];
    end
    return e;
  endfunction

  function automatic InBeat mk(input logic s, input logic inf, input logic zero,
                               input logic [EXP-1:0] e, input logic [FRAC-1:0] f,
                               input logic [TRAIL-1:0] t, input logic st);
    InBeat b;
    b.sign = s; b.isInf = inf; b.isZero = zero; b.exp = e; b.frac = f; b.trail = t; b.sticky = st;
    return b;
  endfunction

  function automatic InBeat randBeat();
    InBeat b;
    int r;
    r = $urandom_range(0, 15);
    b.sign   = 1'($urandom);
    b.isInf  = (r == 0 || r == 1);
    b.isZero = (r == 1 || r == 2);
    case ($urandom_range(0, 3))
      0: b.exp = 8'hFE;
      1: b.exp = 8'hFF;
      default: b.exp = EXP'($urandom);
    endcase
    b.frac   = ($urandom_range(0, 2) == 0) ? 8'hFF : FRAC'($urandom);
    b.trail  = TRAIL'($urandom);
    b.sticky = 1'($urandom);
    return b;
  endfunction

  function automatic OutBeat snap();
    OutBeat o;
    o.sign = bus.outSign; o.isInf = bus.outIsInf; o.isZero = bus.outIsZero;
    o.exp = bus.outExp; o.frac = bus.outFrac; o.inexact = bus.outInexact;
    return o;
  endfunction

  // Called at posedge+1; returns at posedge+1 right after the accepting edge.
  task automatic sendBeat(input InBeat b);
    int waitCnt;
    bit accepted;
    waitCnt = 0;
    accepted = 1'b0;
    bus.inValid = 1'b1;
    bus.inSign = b.sign; bus.inIsInf = b.isInf; bus.inIsZero = b.isZero;
    bus.inExp = b.exp; bus.inFrac = b.frac; bus.inTrailingBits = b.trail; bus.inStickyBit = b.sticky;
    while (!accepted) begin
      @(negedge clock);
      if (bus.inReady) begin
        expQ.push_back(model(b));
        accepted = 1'b1;
      end else begin
        sawInReadyLow = 1'b1;
        waitCnt++;
        if (waitCnt > 500) begin
          nChecks++; nFails++;
          $display("FAIL accept_timeout: got inReady 0 for %0d cycles, expected 1", waitCnt);
          bus.inValid = 1'b0;
          return;
        end
      end
      @(posedge clock); #1;
    end
  endtask

  task automatic idle();
    bus.inValid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (expQ.size() != 0 && n < 500) begin
      @(posedge clock); #1;
      n++;
    end
    check("drain_queue_empty", 64'(expQ.size()), 64'd0);
  endtask

  always @(posedge clock) begin
    if (randomReady) begin
      #1;
      if (randomReady) bus.outReady = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin : monitor
    bit     haveHold;
    OutBeat held;
    Expect  e;
    haveHold = 1'b0;
    held = '0;
    forever begin
      @(negedge clock);
      if (!resetn) begin
        haveHold = 1'b0;
        continue;
      end
      if (!bus.inReady) sawInReadyLow = 1'b1;
      if (haveHold) begin
        check("stall_valid_held", 64'(bus.outValid), 64'd1);
        check("stall_data_stable", 64'(snap()), 64'(held));
      end
      if (bus.outValid && bus.outReady) begin
        if (expQ.size() == 0) begin
          nChecks++; nFails++;
          $display("FAIL unexpected_beat: got %0h, expected no beat", snap());
        end else begin
          e = expQ.pop_front();
          check("beat_data", 64'(snap()), 64'(e.beat));
`ifdef FLOAT_ROUND_STATS_EN
          if (e.beat.inexact) modelInexact++;
          if (e.ovf) modelOverflow++;
`endif
        end
      end
      haveHold = bus.outValid && !bus.outReady;
      held = snap();
    end
  end

  initial begin : main
    int validSeen;
    bus.inValid = 1'b0; bus.inSign = 1'b0; bus.inIsInf = 1'b0; bus.inIsZero = 1'b0;
    bus.inExp = '0; bus.inFrac = '0; bus.inTrailingBits = '0; bus.inStickyBit = 1'b0;
    bus.outReady = 1'b1;
`ifdef FLOAT_ROUND_STATS_EN
    statClear = 1'b0;
`endif
    #2;
    check("reset_outValid", 64'(bus.outValid), 64'd0);
    check("reset_inReady", 64'(bus.inReady), 64'd1);
    check("reset_outData", 64'(snap()), 64'd0);
    @(posedge clock); @(posedge clock); #1;
    resetn = 1'b1;
    @(negedge clock);
    check("post_reset_inReady", 64'(bus.inReady), 64'd1);
    @(posedge clock); #1;

    // Latency: tie with odd LSB rounds up, output two edges after acceptance.
    sendBeat(mk(1'b0, 1'b0, 1'b0, 8'h20, 8'h55, 2'b10, 1'b0));
    idle();
    @(negedge clock);
    check("latency_not_yet", 64'(bus.outValid), 64'd0);
    @(negedge clock);
    check("latency_two", 64'(bus.outValid), 64'd1);
    @(posedge clock); #1;

    sendBeat(mk(1'b1, 1'b0, 1'b0, 8'h20, 8'h54, 2'b10, 1'b0));
    sendBeat(mk(1'b0, 1'b0, 1'b0, 8'h20, 8'h54, 2'b00, 1'b0));
    sendBeat(mk(1'b0, 1'b0, 1'b0, 8'h10, 8'hFF, 2'b11, 1'b0));
    sendBeat(mk(1'b1, 1'b0, 1'b0, 8'hFE, 8'hFF, 2'b11, 1'b0));
    sendBeat(mk(1'b1, 1'b0, 1'b1, 8'h33, 8'h77, 2'b11, 1'b1));
    sendBeat(mk(1'b0, 1'b1, 1'b0, 8'h44, 8'hFF, 2'b11, 1'b1));
    sendBeat(mk(1'b1, 1'b1, 1'b1, 8'h44, 8'h12, 2'b10, 1'b0));
    sendBeat(mk(1'b1, 1'b0, 1'b0, 8'hFF, 8'hFF, 2'b11, 1'b0));
    sendBeat(mk(1'b0, 1'b0, 1'b0, 8'h01, 8'h80, 2'b01, 1'b1));
    sendBeat(mk(1'b0, 1'b0, 1'b0, 8'h01, 8'h80, 2'b10, 1'b1));
    idle();
    drain();

    // Stall mid-stream with four back-to-back beats.
    sawInReadyLow = 1'b0;
    fork
      begin
        for (int i = 0; i < 4; i++) sendBeat(randBeat());
        idle();
      end
      begin
        repeat (2) @(posedge clock);
        #1 bus.outReady = 1'b0;
        repeat (3) @(posedge clock);
        #1 bus.outReady = 1'b1;
      end
    join
    drain();
    check("stall_inReady_dropped", 64'(sawInReadyLow), 64'd1);

    // Random traffic with random backpressure.
    randomReady = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        idle();
        @(posedge clock); #1;
      end
      sendBeat(randBeat());
    end
    idle();
    randomReady = 1'b0;
    @(posedge clock); #1;
    bus.outReady = 1'b1;
    drain();

`ifdef FLOAT_ROUND_STATS_EN
    @(posedge clock); #1;
    check("stat_inexact", 64'(statInexactCount), 64'(modelInexact));
    check("stat_overflow", 64'(statOverflowCount), 64'(modelOverflow));
    statClear = 1'b1;
    @(posedge clock); #1;
    statClear = 1'b0;
    check("stat_clear_inexact", 64'(statInexactCount), 64'd0);
    check("stat_clear_overflow", 64'(statOverflowCount), 64'd0);
    modelInexact = 0;
    modelOverflow = 0;
`endif

    // Reset with two beats in flight discards them.
    bus.outReady = 1'b0;
    sendBeat(randBeat());
    sendBeat(randBeat());
    idle();
    @(posedge clock); #1;
    resetn = 1'b0;
    #1;
    check("midreset_outValid", 64'(bus.outValid), 64'd0);
    check("midreset_inReady", 64'(bus.inReady), 64'd1);
    expQ.delete();
`ifdef FLOAT_ROUND_STATS_EN
    modelInexact = 0;
    modelOverflow = 0;
`endif
    @(posedge clock); #1;
    resetn = 1'b1;
    bus.outReady = 1'b1;
    validSeen = 0;
    repeat (6) begin
      @(negedge clock);
      if (bus.outValid) validSeen++;
    end
    check("midreset_no_emit", 64'(validSeen), 64'd0);
    @(posedge clock); #1;

    sendBeat(mk(1'b1, 1'b0, 1'b1, 8'h00, 8'h00, 2'b11, 1'b0));
    sendBeat(mk(1'b0, 1'b0, 1'b0, 8'hFE, 8'hFF, 2'b11, 1'b1));
    idle();
    drain();
`ifdef FLOAT_ROUND_STATS_EN
    @(posedge clock); #1;
    check("stat_overflow_after_reset", 64'(statOverflowCount), 64'(modelOverflow));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nChecks, nFails);
    $finish;
  end

endmodule
